// File: rtl/echo_delay_line_if.sv
// Sample stream bundle for the echo stage: qualified input sample in,
// qualified mixed sample out, plus the busy indication.
interface echo_delay_line_if;
  logic [15:0] sample_in;
  logic        in_ready;
  logic [15:0] sample_out;
  logic        out_ready;
  logic        busy;

  modport master (
    output sample_in,
    output in_ready,
    input  sample_out,
    input  out_ready,
    input  busy
  );

  modport slave (
    input  sample_in,
    input  in_ready,
    output sample_out,
    output out_ready,
    output busy
  );
endinterface

// File: rtl/echo_delay_line.sv
// Feedback echo stage: mixes each sample with an attenuated copy of the output
// from D samples earlier, held in a DEPTH x 16 synchronous RAM.
module echo_delay_line #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  echo_delay_line_if.slave   bus,
  input  logic               next_delay,
  input  logic               next_att,
  output logic [1:0]         delay_sel,
  output logic [2:0]         att_sel
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, OUT} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   delay_len;
  logic signed [15:0]      mem [DEPTH];
  logic signed [15:0]      rd_data;
  logic signed [15:0]      sample_lat;
  logic [2:0]              att_lat;
  logic [1:0]              cp_valid;
  logic [15:0]             cp_data0;
  logic [15:0]             cp_data1;
  logic signed [15:0]      echo_term;
  logic signed [16:0]      mix_sum;
  logic signed [15:0]      mix_sat;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic signed [15:0]      mem_wdata;

  // D mod DEPTH; the full-depth preset wraps to 0 so the read hits the write slot.
  assign delay_len = {delay_sel + 2'd1, {(ADDR_WIDTH-2){1'b0}}};

  assign bus.busy = (state != IDLE) || (|cp_valid);

  always_comb begin
    echo_term = (att_lat == 3'd0) ? 16'sd0 : (rd_data >>> att_lat);
    mix_sum   = {sample_lat[15], sample_lat} + {echo_term[15], echo_term};
    case (mix_sum[16:15])
      2'b01:   mix_sat = 16'sh7FFF;
      2'b10:   mix_sat = 16'sh8000;
      default: mix_sat = mix_sum[15:0];
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = mix_sat;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clear_addr;
        mem_wdata = 16'sd0;
      end else if (state == MIX) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[rd_addr];
  end

  // Samples arriving during the clear sweep bypass the RAM through a short
  // pipeline so they keep the normal three-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CLEAR;
      clear_addr     <= '0;
      wr_ptr         <= '0;
      rd_addr        <= '0;
      sample_lat     <= 16'sd0;
      att_lat        <= 3'd0;
      cp_valid       <= 2'b00;
      cp_data0       <= 16'd0;
      cp_data1       <= 16'd0;
      delay_sel      <= 2'd0;
      att_sel        <= 3'd1;
      bus.sample_out <= 16'd0;
      bus.out_ready  <= 1'b0;
    end else begin
      bus.out_ready <= 1'b0;
      if (next_delay) delay_sel <= delay_sel + 2'd1;
      if (next_att)   att_sel   <= (att_sel >= 3'd4) ? 3'd0 : att_sel + 3'd1;

      cp_valid <= {cp_valid[0], (state == CLEAR) && bus.in_ready};
      cp_data0 <= bus.sample_in;
      cp_data1 <= cp_data0;
      if (cp_valid[1]) begin
        bus.sample_out <= cp_data1;
        bus.out_ready  <= 1'b1;
      end

      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + ADDR_WIDTH'(1);
          if (clear_addr == ADDR_WIDTH'(DEPTH-1)) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end
        end
        IDLE: begin
          if (bus.in_ready) begin
            sample_lat <= bus.sample_in;
            att_lat    <= att_sel;
            rd_addr    <= wr_ptr - delay_len;
            state      <= READ;
          end
        end
        READ: state <= MIX;
        MIX: begin
          bus.sample_out <= mix_sat;
          bus.out_ready  <= 1'b1;
          wr_ptr         <= wr_ptr + ADDR_WIDTH'(1);
          state          <= OUT;
        end
        OUT:     state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
